// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op encodings, FSM states and step sizing shared by shift_seq
package shift_pkg;

  localparam logic [1:0] SLL   = 2'b00;
  localparam logic [1:0] SRL   = 2'b01;
  localparam logic [1:0] UNDEF = 2'b10;
  localparam logic [1:0] SRA   = 2'b11;

  // Wide enough for the largest per-cycle step (4 in the fast build)
  localparam int STEP_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shifter applying one per-cycle step of shift_seq
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]        i_op,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [STEP_W-1:0] i_amt,
  output logic [WIDTH-1:0]  o_data
);

  always_comb begin
    o_data = '0;
    case (i_op)
      SLL:     o_data = i_data << i_amt;
      SRL:     o_data = i_data >> i_amt;
      SRA:     o_data = $signed(i_data) >>> i_amt;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle sll/srl/sra sequencer; SHIFT_SEQ_FAST4_EN enables 4-bit steps
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shiftout
);

  localparam int SHW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nx;
  logic [SHW-1:0]     r_cnt;
  logic [SHW-1:0]     w_cnt_nx;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_work_nx;
  logic [1:0]         r_op;
  logic [1:0]         w_op_nx;

  logic [SHW-1:0]     w_shamt;
  logic               w_in_shift;
  logic [WIDTH-1:0]   w_src;
  logic [1:0]         w_src_op;
  logic [SHW-1:0]     w_src_cnt;
  logic [STEP_W-1:0]  w_step;
  logic [SHW-1:0]     w_rem;
  logic [WIDTH-1:0]   w_stepped;
  logic               w_unused_b;

  assign w_shamt    = B[SHW-1:0];
  assign w_unused_b = ^B[WIDTH-1:SHW];

  // The accept edge already performs the first step, so done lands max(shamt,1)
  // cycles after accept; during SHIFT the shifter works on the held register.
  assign w_in_shift = (r_state == SHIFT);
  assign w_src      = w_in_shift ? r_work : A;
  assign w_src_op   = w_in_shift ? r_op   : ALUOp;
  assign w_src_cnt  = w_in_shift ? r_cnt  : w_shamt;

`ifdef SHIFT_SEQ_FAST4_EN
  assign w_step = (w_src_cnt >= SHW'(4)) ? STEP_W'(4) : w_src_cnt[STEP_W-1:0];
`else
  assign w_step = STEP_W'(1);
`endif

  assign w_rem = w_src_cnt - SHW'(w_step);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op   (w_src_op),
    .i_data (w_src),
    .i_amt  (w_step),
    .o_data (w_stepped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_op    <= SLL;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_work  <= w_work_nx;
      r_op    <= w_op_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_work_nx  = r_work;
    w_op_nx    = r_op;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_op_nx = ALUOp;
          if (ALUOp == UNDEF) begin
            w_work_nx  = '0;
            w_cnt_nx   = '0;
            w_state_nx = DONE;
          end else if (w_shamt == '0) begin
            w_work_nx  = A;
            w_cnt_nx   = '0;
            w_state_nx = DONE;
          end else begin
            w_work_nx  = w_stepped;
            w_cnt_nx   = w_rem;
            w_state_nx = (w_rem == '0) ? DONE : SHIFT;
          end
        end else if (r_state == DONE) begin
          w_state_nx = IDLE;
        end
      end
      SHIFT: begin
        w_work_nx = w_stepped;
        w_cnt_nx  = w_rem;
        if (w_rem == '0) begin
          w_state_nx = DONE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign ready    = (r_state == IDLE) || (r_state == DONE);
  assign busy     = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign shiftout = r_work;

endmodule
